// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the SDRAM command-port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 19;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_e;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } client_e;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep request holding slot: loads when free, clear has priority over load.
module mem_req_slot
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        data_d = data_q;
        if (clear_i) begin
            busy_d = 1'b0;
        end else if (load_i && !busy_q) begin
            busy_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign busy_o = busy_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM command port between a write and a read client,
// with a bounded wait for read responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_busy,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_busy,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              cmd_valid,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              cmd_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    client_e           last_q, last_d;
    client_e           grant_q, grant_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_err_q, rd_err_d;

    logic              wr_clear, rd_clear;
    logic              wr_full, rd_full;
    logic [ADDR_W-1:0] wr_slot_addr, rd_slot_addr;
    logic [DATA_W-1:0] wr_slot_data, rd_slot_data;

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_slot (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (wr_req),
        .clear_i (wr_clear),
        .addr_i  (wr_addr),
        .data_i  (wr_data),
        .busy_o  (wr_full),
        .addr_o  (wr_slot_addr),
        .data_o  (wr_slot_data)
    );

    // Read slot carries no payload; its zero data field drives cmd_wdata on reads.
    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_slot (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (rd_req),
        .clear_i (rd_clear),
        .addr_i  (rd_addr),
        .data_i  ('0),
        .busy_o  (rd_full),
        .addr_o  (rd_slot_addr),
        .data_o  (rd_slot_data)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        rd_data_d   = rd_data_q;
        rd_err_d    = rd_err_q;
        wr_clear    = 1'b0;
        rd_clear    = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_full || rd_full) begin
                    if (wr_full && rd_full) begin
                        grant_d = (last_q == READ) ? WRITE : READ;
                    end else begin
                        grant_d = wr_full ? WRITE : READ;
                    end
                    last_d  = grant_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Fields are captured once on entry, so they cannot move under backpressure.
                if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    cmd_write_d = (grant_q == WRITE);
                    cmd_addr_d  = (grant_q == WRITE) ? wr_slot_addr : rd_slot_addr;
                    cmd_wdata_d = (grant_q == WRITE) ? wr_slot_data : rd_slot_data;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (cmd_write_q) begin
                        wr_done_d = 1'b1;
                        wr_clear  = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = CNT_W'(TIMEOUT);
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (rsp_valid) begin
                    rd_data_d = rsp_data;
                    rd_done_d = 1'b1;
                    rd_clear  = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == '0) begin
                    rd_data_d = '0;
                    rd_done_d = 1'b1;
                    rd_err_d  = 1'b1;
                    rd_clear  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= READ;
            grant_q     <= WRITE;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= '0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
            rd_data_q   <= rd_data_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign wr_busy   = wr_full;
    assign rd_busy   = rd_full;
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;
    assign rd_data   = rd_data_q;
    assign rd_err    = rd_err_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_write = cmd_write_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expectations, a negedge monitor checks them.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 19;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_req = 1'b0, rd_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_busy, wr_done, rd_busy, rd_done, rd_err;
    logic [DW-1:0] rd_data;
    logic          cmd_valid, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_ready = 1'b0, rsp_valid = 1'b0;
    logic [DW-1:0] rsp_data = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_busy(wr_busy), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy), .rd_done(rd_done),
        .rd_data(rd_data), .rd_err(rd_err),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wcmd_t;
    typedef struct packed { logic [DW-1:0] data; logic err; int unsigned at; } rrsp_t;

    wcmd_t         exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [AW-1:0] rsp_addr_q[$];
    rrsp_t         exp_rsp[$];
    int unsigned   exp_wdone_at[$];
    int unsigned   exp_wlat[$];
    bit            exp_order[$];

    int  checks = 0, failures = 0;
    bit  wr_pend = 0, rd_pend = 0, err_model = 0, run = 0, abort = 0, resp_busy = 0;
    bit  prev_valid = 0, prev_ready = 0, use_fixed_data = 0;
    int  ready_mode = 0;
    int unsigned fixed_delay = 0, n_wr_hs = 0;
    logic [DW-1:0] fixed_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] x;
        x = {13'h0, a};
        return (x * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    // Memory side: command-ready pattern, changed just after the active edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = 1'b0;
        endcase
    end

    // Memory side: answers each read after a chosen delay; delays past TMO+1 must time out.
    initial forever begin
        int unsigned h, d;
        logic [AW-1:0] a;
        logic [DW-1:0] word;
        bit ok;
        @(negedge clk);
        if (run && cmd_valid && cmd_ready && !cmd_write && rsp_addr_q.size() > 0) begin
            resp_busy = 1;
            h = cyc + 1;
            a = rsp_addr_q.pop_front();
            if (fixed_delay != 0) d = fixed_delay;
            else if ($urandom_range(0, 7) == 0) d = TMO + 2;
            else d = $urandom_range(1, TMO + 1);
            word = use_fixed_data ? fixed_data : mem_word(a);
            ok = (d <= TMO + 1);
            if (!ok) err_model = 1;
            exp_rsp.push_back('{ok ? word : '0, err_model, ok ? h + d : h + TMO + 1});
            while (cyc < h + d - 1 && !abort) @(negedge clk);
            if (!abort) begin
                #1;
                rsp_valid = 1'b1;
                rsp_data  = word;
                @(negedge clk);
                #1;
                rsp_valid = 1'b0;
                rsp_data  = $urandom;
            end
            resp_busy = 0;
        end
    end

    // Monitor: compares DUT outputs against queued expectations once per cycle.
    initial forever begin
        @(negedge clk);
        if (run) begin
            chk("wr_busy", 64'(wr_busy), wr_done ? 64'd0 : 64'(wr_pend));
            chk("rd_busy", 64'(rd_busy), rd_done ? 64'd0 : 64'(rd_pend));
            if (prev_valid && !prev_ready) chk("cmd_hold", 64'(cmd_valid), 64'd1);
            if (cmd_valid) begin
                if (cmd_write) begin
                    if (exp_wr.size() == 0) note_fail("cmd_wr_unexpected");
                    else begin
                        chk("cmd_wr_addr", 64'(cmd_addr), 64'(exp_wr[0].addr));
                        chk("cmd_wr_data", 64'(cmd_wdata), 64'(exp_wr[0].data));
                        if (cmd_ready) begin
                            void'(exp_wr.pop_front());
                            exp_wdone_at.push_back(cyc + 1);
                            n_wr_hs++;
                        end
                    end
                end else begin
                    if (exp_rd.size() == 0) note_fail("cmd_rd_unexpected");
                    else begin
                        chk("cmd_rd_addr", 64'(cmd_addr), 64'(exp_rd[0]));
                        if (cmd_ready) void'(exp_rd.pop_front());
                    end
                end
                if (cmd_ready && exp_order.size() > 0)
                    chk("grant_order", 64'(cmd_write), 64'(exp_order.pop_front()));
            end
            if (wr_done) begin
                if (exp_wdone_at.size() == 0) note_fail("wr_done_unexpected");
                else chk("wr_done_cycle", 64'(cyc), 64'(exp_wdone_at.pop_front()));
                if (exp_wlat.size() > 0) chk("wr_latency", 64'(cyc), 64'(exp_wlat.pop_front()));
                wr_pend = 0;
            end
            if (rd_done) begin
                if (exp_rsp.size() == 0) note_fail("rd_done_unexpected");
                else begin
                    rrsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(r.data));
                    chk("rd_err", 64'(rd_err), 64'(r.err));
                    chk("rd_done_cycle", 64'(cyc), 64'(r.at));
                end
                rd_pend = 0;
            end
            prev_valid = cmd_valid;
            prev_ready = cmd_ready;
        end
    end

    task automatic drive_reqs(input bit dw, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input bit dr, input logic [AW-1:0] ra);
        @(negedge clk);
        #1;
        wr_req = dw; wr_addr = wa; wr_data = wd;
        rd_req = dr; rd_addr = ra;
        if (dw && !wr_pend) begin
            exp_wr.push_back('{wa, wd});
            wr_pend = 1;
        end
        if (dr && !rd_pend) begin
            exp_rd.push_back(ra);
            rsp_addr_q.push_back(ra);
            rd_pend = 1;
        end
    endtask

    task automatic idle_cycle();
        drive_reqs(0, '0, '0, 0, '0);
    endtask

    task automatic wait_quiet(input int unsigned budget);
        int unsigned n = 0;
        while ((wr_pend || rd_pend || resp_busy || exp_wr.size() > 0 || exp_rd.size() > 0 ||
                exp_rsp.size() > 0 || exp_wdone_at.size() > 0 || exp_wlat.size() > 0 ||
                exp_order.size() > 0) && n < budget) begin
            idle_cycle();
            n++;
        end
        if (n >= budget) note_fail("wait_budget_expired");
        idle_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_busy"},   64'(wr_busy), 64'd0);
        chk({tag, "_wr_done"},   64'(wr_done), 64'd0);
        chk({tag, "_rd_busy"},   64'(rd_busy), 64'd0);
        chk({tag, "_rd_done"},   64'(rd_done), 64'd0);
        chk({tag, "_rd_err"},    64'(rd_err), 64'd0);
        chk({tag, "_rd_data"},   64'(rd_data), 64'd0);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_cmd_write"}, 64'(cmd_write), 64'd0);
        chk({tag, "_cmd_addr"},  64'(cmd_addr), 64'd0);
        chk({tag, "_cmd_wdata"}, 64'(cmd_wdata), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs0;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        run = 1;

        // Single write with cmd_ready held high: wr_done three cycles after the request.
        ready_mode = 0;
        drive_reqs(1, 19'h00010, 32'hDEADBEEF, 0, '0);
        exp_wlat.push_back(cyc + 4);
        wait_quiet(50);

        // Single read answered five cycles after the handshake.
        fixed_delay = 5; use_fixed_data = 1; fixed_data = 32'h12345678;
        drive_reqs(0, '0, '0, 1, 19'h7FFFF);
        wait_quiet(50);
        use_fixed_data = 0; fixed_delay = 0;

        // Contention: simultaneous requests alternate W,R starting with write.
        for (int r = 0; r < 4; r++) begin
            exp_order.push_back(1'b1);
            exp_order.push_back(1'b0);
            drive_reqs(1, 19'($urandom), $urandom, 1, 19'($urandom));
            wait_quiet(80);
        end

        // Backpressure: command held for ten cycles, second write request ignored.
        ready_mode = 2;
        hs0 = n_wr_hs;
        drive_reqs(1, 19'h2ABCD, 32'hA5A5_0F0F, 0, '0);
        idle_cycle();
        drive_reqs(1, 19'h11111, 32'h2222_3333, 0, '0);
        repeat (10) idle_cycle();
        ready_mode = 0;
        wait_quiet(50);
        chk("bp_single_cmd", 64'(n_wr_hs - hs0), 64'd1);

        // Timeout: no answer in time, then a late strobe that must be ignored.
        fixed_delay = TMO + 2;
        drive_reqs(0, '0, '0, 1, 19'h00123);
        wait_quiet(60);
        chk("rd_err_set", 64'(rd_err), 64'd1);
        fixed_delay = 3;
        drive_reqs(0, '0, '0, 1, 19'h54321);
        wait_quiet(60);
        chk("rd_err_sticky", 64'(rd_err), 64'd1);
        fixed_delay = 0;

        // Randomized traffic with random backpressure and response delays.
        ready_mode = 1;
        for (int i = 0; i < 400; i++)
            drive_reqs($urandom_range(0, 3) == 0, 19'($urandom), $urandom,
                       $urandom_range(0, 3) == 0, 19'($urandom));
        wait_quiet(600);

        // Reset while waiting for a read response.
        ready_mode = 0;
        fixed_delay = TMO + 2;
        drive_reqs(0, '0, '0, 1, 19'h0BEEF);
        begin
            int unsigned n = 0;
            while (!resp_busy && n < 40) begin idle_cycle(); n++; end
            if (!resp_busy) note_fail("reset_test_no_handshake");
        end
        idle_cycle();
        idle_cycle();
        run = 0;
        abort = 1;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        exp_wr.delete(); exp_rd.delete(); rsp_addr_q.delete(); exp_rsp.delete();
        exp_wdone_at.delete(); exp_wlat.delete(); exp_order.delete();
        wr_pend = 0; rd_pend = 0; err_model = 0; prev_valid = 0; prev_ready = 0;
        #1;
        reset_n = 1'b1;
        abort = 0;
        run = 1;
        fixed_delay = 4;
        drive_reqs(0, '0, '0, 1, 19'h0CAFE);
        wait_quiet(60);
        chk("post_reset_err", 64'(rd_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single SDRAM command port (19-bit word address, 32-bit data) between the delay line's write stream and read stream. Each client gets a one-deep request slot, fair round-robin grant and a completion pulse. Reads are bounded by a response timeout. Sits between the delay block's mem_* signals and the memory controller's s2a port, in the clk_50 domain.

## Interface
- ADDR_W, 19, word address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles from read issue to response before abort (1..2^16-1)
- clk  in  1  system clock (clk_50)
- reset_n  in  1  asynchronous, active-low reset
- wr_req  in  1  write request pulse; ignored while wr_busy=1
- wr_addr  in  ADDR_W  write address, sampled with wr_req
- wr_data  in  DATA_W  write data, sampled with wr_req
- wr_busy  out  1  write slot occupied
- wr_done  out  1  one-cycle pulse on write command acceptance
- rd_req  in  1  read request pulse; ignored while rd_busy=1
- rd_addr  in  ADDR_W  read address, sampled with rd_req
- rd_busy  out  1  read slot occupied
- rd_done  out  1  one-cycle pulse, read data valid
- rd_data  out  DATA_W  read result, held until next rd_done
- rd_err  out  1  sticky; set on timeout, cleared only by reset
- cmd_valid  out  1  command to memory
- cmd_write  out  1  1=write, 0=read
- cmd_addr  out  ADDR_W  command address
- cmd_wdata  out  DATA_W  write data
- cmd_ready  in  1  memory accepts command when high with cmd_valid
- rsp_valid  in  1  read data return strobe
- rsp_data  in  DATA_W  read data

## Operation
- Slots: wr_req with wr_busy=0 loads addr/data and sets wr_busy next edge. The same applies to the read slot. A slot clears at its done pulse.
- FSM states IDLE, ISSUE, WAIT_RD.
- IDLE: if exactly one slot is full, grant it. If both are full, grant the client not granted last (`last` resets to READ, so write wins first). Go to ISSUE.
- ISSUE: drive cmd_valid=1 with the granted slot's fields. Fields are stable until the handshake (cmd_valid & cmd_ready).
  - Write handshake: pulse wr_done, clear the slot, go to IDLE.
  - Read handshake: load the timeout counter with TIMEOUT, go to WAIT_RD.
- WAIT_RD: counter decrements each cycle.
  - rsp_valid: rd_data<=rsp_data, pulse rd_done, clear the slot, go to IDLE.
  - Counter reaches 0 without rsp_valid: rd_data<=0, pulse rd_done, set rd_err, go to IDLE.
  - rsp_valid in the same cycle as expiry counts as success.
- rsp_valid outside WAIT_RD is ignored.
- Requests arriving in any state only load a free slot and never disturb an in-flight command.
- A request pulse in the same cycle its slot clears is ignored, because busy is still 1.
- `last` updates on every grant.

## Timing
- Reset values: all busy/done/err/cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, rd_data=0, state IDLE, last=READ.
- wr_req at edge N: wr_busy=1 after N. Grant at N+1, cmd_valid=1 after N+2.
- Best-case write latency: wr_req to wr_done is 3 cycles with cmd_ready held high.
- Read latency: cmd handshake + response delay + 1 registered cycle to rd_done.
- All outputs are registered; no combinational path from any input to any output.
- Reset mid-operation: immediate return to reset values; in-flight command abandoned.

## Structure
- Package mem_arb_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, ISSUE, WAIT_RD), client enum (WRITE, READ).
- Sub-module mem_req_slot (load, clear, busy, stored fields), instantiated twice: write slot with data, read slot with DATA_W tied off.
- Timeout counter width $clog2(TIMEOUT+1).

## Test plan
- Single write: wr_req addr=0x00010 data=0xDEADBEEF, cmd_ready=1 → one cmd_valid cycle with write=1 and those fields; wr_done 3 cycles after wr_req; wr_busy low after.
- Single read: rd_req addr=0x7FFFF, rsp_valid 5 cycles after handshake with 0x12345678 → rd_done one cycle later, rd_data=0x12345678, rd_err=0.
- Contention: wr_req and rd_req same cycle, repeated 4 times with back-to-back completion → grants alternate W,R,W,R,… and write is first after reset.
- Backpressure: cmd_ready low 10 cycles → cmd_valid/addr/data stable throughout; second wr_req during busy ignored (exactly one command issued).
- Timeout: TIMEOUT=8, no rsp_valid → rd_done 9 cycles after handshake with rd_data=0; rd_err=1 and stays 1 after a later successful read; late rsp_valid ignored.
- Reset mid-read: assert reset_n=0 in WAIT_RD → all outputs zero asynchronously; after release a new read completes normally.
